// File: rtl/pulse_measure.sv
// Measures high/low run lengths of a (possibly asynchronous) pulse train and
// reports them as length-minus-one, matching the pulse generator's convention.
module pulse_measure #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] high_len,
  output logic [WIDTH-1:0] low_len,
  output logic             high_valid,
  output logic             low_valid,
  output logic             pair_valid,
  output logic             locked,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ACQUIRE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [WIDTH-1:0]       r_cnt;
  state_t                 r_state;
  logic                   r_have_high;

  logic [WIDTH-1:0]       r_high_len;
  logic [WIDTH-1:0]       r_low_len;
  logic                   r_high_valid;
  logic                   r_low_valid;
  logic                   r_pair_valid;
  logic                   r_locked;
  logic                   r_overflow;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_cnt_max;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_s_d;
  assign w_fall    = ~w_s & r_s_d;
  assign w_cnt_max = &r_cnt;

  // Sync chain and delayed copy both clear to 0, so a level held high through
  // reset shows up as a single rise once reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync[0] <= pulse_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_s_d <= w_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if ((r_state == ACQUIRE) || w_rise || w_fall) begin
      r_cnt <= '0;
    end else if (!w_cnt_max) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  // At an edge r_cnt already holds (cycles at previous level) - 1, and a
  // saturated count is all-ones, so it is captured directly in both cases.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ACQUIRE;
      r_have_high  <= 1'b0;
      r_high_len   <= '0;
      r_low_len    <= '0;
      r_high_valid <= 1'b0;
      r_low_valid  <= 1'b0;
      r_pair_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_high_valid <= 1'b0;
      r_low_valid  <= 1'b0;
      r_pair_valid <= 1'b0;
      case (r_state)
        ACQUIRE: begin
          if (w_rise) begin
            r_locked <= 1'b1;
            r_state  <= MEAS_HIGH;
          end else if (w_fall) begin
            r_locked <= 1'b1;
            r_state  <= MEAS_LOW;
          end
        end
        MEAS_HIGH: begin
          if (w_fall) begin
            r_high_len   <= r_cnt;
            r_high_valid <= 1'b1;
            r_have_high  <= 1'b1;
            if (w_cnt_max) begin
              r_overflow <= 1'b1;
            end
            r_state <= MEAS_LOW;
          end
        end
        MEAS_LOW: begin
          if (w_rise) begin
            r_low_len    <= r_cnt;
            r_low_valid  <= 1'b1;
            r_pair_valid <= r_have_high;
            r_have_high  <= 1'b0;
            if (w_cnt_max) begin
              r_overflow <= 1'b1;
            end
            r_state <= MEAS_HIGH;
          end
        end
        default: begin
          r_state <= ACQUIRE;
        end
      endcase
    end
  end

  assign high_len   = r_high_len;
  assign low_len    = r_low_len;
  assign high_valid = r_high_valid;
  assign low_valid  = r_low_valid;
  assign pair_valid = r_pair_valid;
  assign locked     = r_locked;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_pulse_measure.sv
// Self-checking bench for pulse_measure: three instances (2-stage/32-bit,
// 3-stage/32-bit, 2-stage/4-bit) against a run-length reference model.
module tb_pulse_measure;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic pulse_in = 1'b0;

  logic [31:0] hl0, ll0, hl1, ll1;
  logic [3:0]  hl2, ll2;
  logic        hv0, lv0, pv0, lk0, ov0;
  logic        hv1, lv1, pv1, lk1, ov1;
  logic        hv2, lv2, pv2, lk2, ov2;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  bit     mon_en = 1'b0;

  always #5 clk = ~clk;

  pulse_measure #(.WIDTH(32), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .high_len(hl0), .low_len(ll0), .high_valid(hv0), .low_valid(lv0),
    .pair_valid(pv0), .locked(lk0), .overflow(ov0)
  );

  pulse_measure #(.WIDTH(32), .SYNC_STAGES(3)) u_dut1 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .high_len(hl1), .low_len(ll1), .high_valid(hv1), .low_valid(lv1),
    .pair_valid(pv1), .locked(lk1), .overflow(ov1)
  );

  pulse_measure #(.WIDTH(4), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .high_len(hl2), .low_len(ll2), .high_valid(hv2), .low_valid(lv2),
    .pair_valid(pv2), .locked(lk2), .overflow(ov2)
  );

  logic [68:0] act [3];
  assign act[0] = {lk0, ov0, hv0, lv0, pv0, hl0, ll0};
  assign act[1] = {lk1, ov1, hv1, lv1, pv1, hl1, ll1};
  assign act[2] = {lk2, ov2, hv2, lv2, pv2, 28'd0, hl2, 28'd0, ll2};

  // ---------------- reference model ----------------
  // Works on the stream of pulse_in samples: every level change ends a run of
  // known length, and its report appears SYNC_STAGES edges later.
  typedef struct {
    int     d;
    longint due;
    int     kind;   // 0 = lock, 1 = high report, 2 = low report
    longint len;
    bit     pair;
    bit     ov;
  } ev_t;

  ev_t         evq[$];
  bit          m_prev [3];
  bit          m_acq  [3];
  bit          m_hcap [3];
  longint      m_run  [3];
  bit          e_lock [3];
  bit          e_ov   [3];
  bit          e_hv   [3];
  bit          e_lv   [3];
  bit          e_pv   [3];
  logic [31:0] e_hl   [3];
  logic [31:0] e_ll   [3];

  function automatic int ss_of(input int d);
    return (d == 1) ? 3 : 2;
  endfunction

  function automatic int wd_of(input int d);
    return (d == 2) ? 4 : 32;
  endfunction

  function automatic logic [68:0] exp_pack(input int d);
    return {e_lock[d], e_ov[d], e_hv[d], e_lv[d], e_pv[d], e_hl[d], e_ll[d]};
  endfunction

  always @(posedge clk) begin : model
    ev_t    ev;
    longint mx;
    cyc = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      e_hv[d] = 1'b0;
      e_lv[d] = 1'b0;
      e_pv[d] = 1'b0;
    end
    if (reset) begin
      evq.delete();
      for (int d = 0; d < 3; d++) begin
        e_lock[d] = 1'b0; e_ov[d] = 1'b0; e_hl[d] = '0; e_ll[d] = '0;
        m_prev[d] = 1'b0; m_acq[d] = 1'b1; m_hcap[d] = 1'b0; m_run[d] = 0;
      end
    end else begin
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].due == cyc) begin
          ev = evq[i];
          case (ev.kind)
            0: e_lock[ev.d] = 1'b1;
            1: begin
              e_hl[ev.d] = ev.len[31:0];
              e_hv[ev.d] = 1'b1;
              if (ev.ov) e_ov[ev.d] = 1'b1;
            end
            default: begin
              e_ll[ev.d] = ev.len[31:0];
              e_lv[ev.d] = 1'b1;
              e_pv[ev.d] = ev.pair;
              if (ev.ov) e_ov[ev.d] = 1'b1;
            end
          endcase
          evq.delete(i);
        end
      end
      for (int d = 0; d < 3; d++) begin
        if (pulse_in != m_prev[d]) begin
          mx      = (longint'(1) << wd_of(d)) - 1;
          ev.d    = d;
          ev.due  = cyc + ss_of(d);
          ev.pair = 1'b0;
          ev.ov   = 1'b0;
          ev.len  = 0;
          if (m_acq[d]) begin
            ev.kind   = 0;
            m_acq[d]  = 1'b0;
            m_hcap[d] = 1'b0;
          end else begin
            ev.ov  = (m_run[d] - 1) >= mx;
            ev.len = ev.ov ? mx : (m_run[d] - 1);
            if (m_prev[d]) begin
              ev.kind   = 1;
              m_hcap[d] = 1'b1;
            end else begin
              ev.kind   = 2;
              ev.pair   = m_hcap[d];
              m_hcap[d] = 1'b0;
            end
          end
          evq.push_back(ev);
          m_run[d]  = 1;
          m_prev[d] = pulse_in;
        end else begin
          m_run[d] = m_run[d] + 1;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== exp_pack(d)) begin
          errors++;
          $display("FAIL model_cmp dut%0d cyc=%0d got=%h exp=%h", d, cyc, act[d], exp_pack(d));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset(input bit lvl, input int n);
    @(negedge clk);
    reset    = 1'b1;
    pulse_in = lvl;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input bit lvl, input int n);
    repeat (n) begin
      @(negedge clk);
      pulse_in = lvl;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset    = 1'b1;
    pulse_in = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act[d] !== '0) begin
          errors++;
          $display("FAIL reset_state dut%0d got=%h exp=0", d, act[d]);
        end
      end
    end
    @(negedge clk);
    mon_en = 1'b1;
    reset  = 1'b0;
  endtask

  task automatic test_period_4_6();
    int nh = 0;
    int nl = 0;
    bit lvl;
    apply_reset(1'b0, 2);
    for (int c = 0; c < 55; c++) begin
      lvl = (c >= 5) && (((c - 5) % 10) < 4);
      @(negedge clk); pulse_in = lvl;
      @(posedge clk); #1;
      if (hv0) begin
        nh++; checks++;
        if (hl0 !== 32'd3) begin errors++; $display("FAIL period_high_len got=%0d exp=3", hl0); end
      end
      if (lv0) begin
        nl++; checks++;
        if (ll0 !== 32'd5 || pv0 !== 1'b1) begin
          errors++; $display("FAIL period_low got len=%0d pair=%b exp len=5 pair=1", ll0, pv0);
        end
      end
    end
    checks++;
    if (nh != 5 || nl != 4) begin errors++; $display("FAIL period_counts got h=%0d l=%0d exp h=5 l=4", nh, nl); end
    checks++;
    if (ov0 !== 1'b0 || lk0 !== 1'b1) begin errors++; $display("FAIL period_flags got ov=%b lk=%b exp ov=0 lk=1", ov0, lk0); end
  endtask

  task automatic test_toggle();
    int nh = 0, nl = 0, np = 0, ns = 0, first = -1, last = -1;
    bit lvl;
    apply_reset(1'b0, 2);
    for (int c = 0; c < 28; c++) begin
      lvl = (c >= 3) && (c < 23) && (((c - 3) % 2) == 0);
      @(negedge clk); pulse_in = lvl;
      @(posedge clk); #1;
      if (hv0 || lv0) begin
        ns++;
        if (first < 0) first = c;
        last = c;
      end
      if (hv0) begin
        nh++; checks++;
        if (hl0 !== 32'd0 || lv0 !== 1'b0) begin errors++; $display("FAIL toggle_high got len=%0d lv=%b exp len=0 lv=0", hl0, lv0); end
      end
      if (lv0) begin
        nl++;
        if (pv0) np++;
        checks++;
        if (ll0 !== 32'd0) begin errors++; $display("FAIL toggle_low_len got=%0d exp=0", ll0); end
      end
    end
    checks++;
    if (nh != 10 || nl != 9 || np != 9) begin
      errors++; $display("FAIL toggle_counts got h=%0d l=%0d p=%0d exp h=10 l=9 p=9", nh, nl, np);
    end
    checks++;
    if (ns != 19 || (last - first) != 18) begin
      errors++; $display("FAIL toggle_consecutive got n=%0d span=%0d exp n=19 span=18", ns, last - first);
    end
  endtask

  task automatic test_held_high();
    int ns = 0;
    apply_reset(1'b1, 3);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); pulse_in = 1'b1;
      @(posedge clk); #1;
      if (hv0 || lv0 || pv0) ns++;
    end
    checks++;
    if (ns != 0 || lk0 !== 1'b1) begin errors++; $display("FAIL held_high got strobes=%0d lk=%b exp strobes=0 lk=1", ns, lk0); end
    checks++;
    if (hl0 !== 32'd0 || ll0 !== 32'd0) begin errors++; $display("FAIL held_high_lens got h=%0d l=%0d exp 0 0", hl0, ll0); end
  endtask

  task automatic test_latency();
    apply_reset(1'b0, 2);
    drive(1'b0, 3);
    drive(1'b1, 7);
    @(negedge clk); pulse_in = 1'b0;
    @(posedge clk); #1;                       // edge k: fall first sampled
    @(posedge clk); #1;                       // k+1
    checks++;
    if (hv0 !== 1'b0) begin errors++; $display("FAIL latency_ss2_early got hv=%b exp 0", hv0); end
    @(posedge clk); #1;                       // k+2
    checks++;
    if (hv0 !== 1'b1 || hl0 !== 32'd6) begin errors++; $display("FAIL latency_ss2 got hv=%b len=%0d exp hv=1 len=6", hv0, hl0); end
    checks++;
    if (hv1 !== 1'b0) begin errors++; $display("FAIL latency_ss3_early got hv=%b exp 0", hv1); end
    @(posedge clk); #1;                       // k+3
    checks++;
    if (hv1 !== 1'b1 || hl1 !== 32'd6 || hv0 !== 1'b0) begin
      errors++; $display("FAIL latency_ss3 got hv3=%b len=%0d hv2=%b exp hv3=1 len=6 hv2=0", hv1, hl1, hv0);
    end
    drive(1'b0, 3);
  endtask

  task automatic test_saturation();
    int runs [4] = '{20, 5, 4, 5};
    int k2 = 0;
    int k0 = 0;
    apply_reset(1'b0, 2);
    drive(1'b0, 2);
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < runs[r]; n++) begin
        @(negedge clk); pulse_in = ((r % 2) == 0);
        @(posedge clk); #1;
        if (hv2) begin
          k2++; checks++;
          if (k2 == 1 && (hl2 !== 4'd15 || ov2 !== 1'b1)) begin
            errors++; $display("FAIL sat_first got len=%0d ov=%b exp len=15 ov=1", hl2, ov2);
          end else if (k2 == 2 && (hl2 !== 4'd3 || ov2 !== 1'b1)) begin
            errors++; $display("FAIL sat_second got len=%0d ov=%b exp len=3 ov=1", hl2, ov2);
          end
        end
        if (hv0 && k0 == 0) begin
          k0++; checks++;
          if (hl0 !== 32'd19 || ov0 !== 1'b0) begin errors++; $display("FAIL sat_wide got len=%0d ov=%b exp len=19 ov=0", hl0, ov0); end
        end
      end
    end
    checks++;
    if (k2 != 2 || ov2 !== 1'b1) begin errors++; $display("FAIL sat_count got n=%0d ov=%b exp n=2 ov=1", k2, ov2); end
  endtask

  task automatic test_reset_mid();
    bit lvl;
    bit got = 1'b0;
    apply_reset(1'b0, 2);
    drive(1'b0, 3); drive(1'b1, 4); drive(1'b0, 6); drive(1'b1, 4); drive(1'b0, 3);
    @(negedge clk); reset = 1'b1; pulse_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (act[0] !== '0) begin errors++; $display("FAIL reset_mid_clear got=%h exp=0", act[0]); end
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (lk0 !== 1'b0 || hv0 !== 1'b0 || lv0 !== 1'b0) begin
        errors++; $display("FAIL reset_mid_idle got lk=%b hv=%b lv=%b exp 0 0 0", lk0, hv0, lv0);
      end
      @(negedge clk); pulse_in = 1'b0;
    end
    for (int c = 0; c < 20; c++) begin
      lvl = (c < 4) || (c >= 10 && c < 14);
      pulse_in = lvl;
      @(posedge clk); #1;
      if (!got && (hv0 || lv0)) begin
        got = 1'b1; checks++;
        if (hv0 !== 1'b1 || lv0 !== 1'b0 || hl0 !== 32'd3) begin
          errors++; $display("FAIL reset_mid_first got hv=%b lv=%b len=%0d exp hv=1 lv=0 len=3", hv0, lv0, hl0);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin errors++; $display("FAIL reset_mid_nostrobe got none exp one"); end
  endtask

  task automatic test_random();
    bit lvl = 1'b0;
    int len;
    apply_reset(1'b0, 2);
    for (int r = 0; r < 40; r++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 7) == 0) apply_reset(lvl, $urandom_range(1, 2));
      drive(lvl, len);
    end
    drive(lvl, 6);
    checks++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL random_overflow got ov0=%b ov1=%b exp 0 0", ov0, ov1); end
  endtask

  initial begin
    test_reset();
    test_period_4_6();
    test_toggle();
    test_held_high();
    test_latency();
    test_saturation();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
